// File: rtl/imem_fetch_ctrl_pkg.sv
// rtl/imem_fetch_ctrl_pkg.sv - shared sizes and state encoding for the instruction fetch controller
package fetch_pkg;

  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 10;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - byte-memory port between the fetch controller and imem_bram
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - boots the byte memory from the loader, then assembles 32-bit
// little-endian instructions from four single-byte reads.
module imem_fetch_ctrl #(
  parameter int MEM_SIZE = fetch_pkg::MEM_SIZE,
  parameter int ADDR_W   = fetch_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_pc,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        instr_out,
  output logic               instr_valid,
  output logic               fetch_stall,
  input  logic               ld_valid,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
  input  logic               ld_done,
  output logic               ld_ready,
  imem_fetch_ctrl_if.master  mem
);

  import fetch_pkg::*;

  localparam logic [ADDR_W:0] LP_SIZE = (ADDR_W+1)'(MEM_SIZE);

  fetch_state_e      r_state;
  fetch_state_e      w_next;
  logic [1:0]        r_k;
  logic [ADDR_W-1:0] r_base;
  logic [23:0]       r_buf;
  logic [31:0]       r_instr;
  logic              r_valid;

  logic              w_load;
  logic              w_finish;
  logic [ADDR_W-1:0] w_new_base;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_unused_pc;

  // Upper PC bits address nothing in this memory.
  assign w_unused_pc  = ^{fetch_pc[31:ADDR_W], redirect_pc[31:ADDR_W]};
  assign w_new_base   = redirect ? redirect_pc[ADDR_W-1:0] : fetch_pc[ADDR_W-1:0];
  assign w_sum        = {1'b0, r_base} + {{(ADDR_W-1){1'b0}}, r_k};
  assign w_issue_addr = ADDR_W'((w_sum >= LP_SIZE) ? (w_sum - LP_SIZE) : w_sum);

  assign instr_out   = r_instr;
  assign instr_valid = r_valid;

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_finish      = 1'b0;
    ld_ready      = 1'b0;
    fetch_stall   = 1'b1;
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      ST_BOOT: begin
        ld_ready      = 1'b1;
        mem.mem_en    = ld_valid;
        mem.mem_we    = ld_valid;
        mem.mem_addr  = ld_addr;
        mem.mem_wdata = ld_data;
        if (ld_done) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE, ST_DONE: begin
        fetch_stall = 1'b0;
        if (redirect || fetch_req) begin
          w_load = 1'b1;
          w_next = ST_ISSUE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        mem.mem_en   = 1'b1;
        mem.mem_addr = w_issue_addr;
        if (redirect) begin
          w_load = 1'b1;
          w_next = ST_ISSUE;
        end else if (r_k == 2'd3) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          w_load = 1'b1;
          w_next = ST_ISSUE;
        end else begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end
      end
      default: w_next = ST_BOOT;
    endcase
  end

  // Read data lags the address by a cycle, so issue slot k captures byte k-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_k     <= 2'd0;
      r_base  <= '0;
      r_buf   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_finish;
      if (w_load) begin
        r_base <= w_new_base;
        r_k    <= 2'd0;
        r_buf  <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_k <= r_k + 2'd1;
        case (r_k)
          2'd1:    r_buf[7:0]   <= mem.mem_rdata;
          2'd2:    r_buf[15:8]  <= mem.mem_rdata;
          2'd3:    r_buf[23:16] <= mem.mem_rdata;
          default: ;
        endcase
      end
      if (w_finish) begin
        r_instr <= {mem.mem_rdata, r_buf};
      end
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 10, byte-address width, equal to log2(MEM_SIZE).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fetch_req  in  1  IF requests the instruction at fetch_pc.
REQ-006 fetch_pc  in  32  byte address of the requested instruction.
REQ-007 redirect  in  1  branch taken in decode; abort any fetch and use redirect_pc.
REQ-008 redirect_pc  in  32  branch target address.
REQ-009 instr_out  out  32  assembled instruction.
REQ-010 instr_valid  out  1  one-cycle pulse; instr_out is valid.
REQ-011 fetch_stall  out  1  stall request to the hazard/IF logic.
REQ-012 ld_valid  in  1  loader offers a byte.
REQ-013 ld_addr  in  ADDR_W  loader byte address.
REQ-014 ld_data  in  8  loader byte.
REQ-015 ld_done  in  1  loader has finished (pulse).
REQ-016 ld_ready  out  1  controller accepts the loader byte.
REQ-017 mem_en, mem_we  out  1 each  byte-memory enable and write strobe.
REQ-018 mem_addr  out  ADDR_W  byte-memory address.
REQ-019 mem_wdata  out  8  byte-memory write data.
REQ-020 mem_rdata  in  8  byte-memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-021 SHALL implement the states BOOT, IDLE, ISSUE, WAIT and DONE.
REQ-022 BOOT: ld_ready=1 and mem_en=mem_we=ld_valid, with mem_addr=ld_addr and mem_wdata=ld_data; fetch_req and redirect are ignored.
REQ-023 BOOT: ld_done SHALL move the controller to IDLE on the next edge; a ld_valid in the same cycle SHALL still be written.
REQ-024 Outside BOOT: ld_ready=0; ld_valid and ld_done are ignored; mem_we=0.
REQ-025 In IDLE or DONE:
- redirect latches redirect_pc; otherwise fetch_req latches fetch_pc.
- Either one starts ISSUE with byte counter k=0.
- If both are asserted, redirect wins.
REQ-026 ISSUE: mem_en=1 and mem_addr=(base+k) mod MEM_SIZE, for k=0..3, one byte per cycle; after k=3 the controller moves to WAIT.
REQ-027 ISSUE/WAIT: the mem_rdata returned for byte k SHALL be captured into bits [8k+7:8k]; the byte at address base goes to [7:0], base+3 to [31:24].
REQ-028 WAIT captures byte 3, then moves to DONE.
REQ-029 DONE:
- instr_valid=1 for exactly one cycle.
- instr_out holds its value until the next DONE.
REQ-030 Latency: request sampled at edge T -> instr_valid high in the cycle after edge T+5 (6 cycles, with no redirect).
REQ-031 A redirect in ISSUE or WAIT SHALL:
- discard the partial bytes;
- latch redirect_pc;
- restart ISSUE at k=0 on the next edge;
- produce no instr_valid for the aborted fetch.
REQ-032 Address wrap: base=1022 issues 1022, 1023, 0, 1. Unaligned base SHALL be supported, with no fault.
REQ-033 fetch_pc/redirect_pc bits above ADDR_W SHALL be ignored.
REQ-034 fetch_stall SHALL be 1 in BOOT, ISSUE and WAIT, and 0 in IDLE and DONE.

Reset
REQ-035 reset at any edge, including mid-fetch or mid-load, SHALL force:
- state BOOT, k=0;
- instr_out=0, instr_valid=0;
- latched base=0;
- no pending write.
REQ-036 After reset: mem_en=0 unless ld_valid, ld_ready=1, fetch_stall=1.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum, MEM_SIZE and ADDR_W.
REQ-038 No sub-module inside this block; the byte memory imem_bram (single-port, one-cycle read) SHALL be instantiated beside it at IF level.
REQ-039 Memory control outputs SHALL be decoded combinationally from the state and counter; instr_out, instr_valid and base SHALL be registers.

Verification
REQ-040 Boot load: write 0x13,0x05,0xA0,0x00 to addresses 0..3, then ld_done, then fetch_req with pc=0 -> instr_out=0x00A00513 and instr_valid exactly 6 cycles after the request.
REQ-041 Wrap: bytes 0xDD@1022, 0xCC@1023, 0xBB@0, 0xAA@1, fetch pc=1022 -> mem_addr sequence 1022,1023,0,1 and instr_out=0xAABBCCDD.
REQ-042 Redirect during ISSUE at k=2 with redirect_pc=8 -> no instr_valid for the old fetch; restart addresses 8..11; valid 6 cycles after the redirect.
REQ-043 fetch_req and redirect together in IDLE with pc=4 and redirect_pc=12 -> first mem_addr=12.
REQ-044 Reset asserted in WAIT -> next cycle state BOOT, instr_valid=0, instr_out=0, fetch_stall=1, ld_ready=1.
REQ-045 ld_valid after boot, with ld_addr=0 and data 0xFF -> mem_we stays 0; byte 0 unchanged on a later fetch.
